// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of imem_loader.
// master = stream source / supervisor side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 7
) ();
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a big-endian word stream (16-bit count header + 4*N bytes) into instruction memory.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_FINISH
    } state_t;

    // Where the load goes once all words are written (also for an empty load).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_FINISH;
`endif

    state_t            r_state;
    logic [15:0]       r_count;
    logic [1:0]        r_idx;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_rx_ready;
    logic        w_xfer;
    logic [15:0] w_count;
    logic        w_last;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            S_HDR_HI, S_HDR_LO, S_DATA: w_rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                      w_rx_ready = 1'b1;
`endif
            default:                    w_rx_ready = 1'b0;
        endcase
    end

    assign w_xfer  = bus.rx_valid & w_rx_ready;
    assign w_count = {r_count[15:8], bus.rx_data};
    assign w_last  = (16'(r_addr) + 16'd1) == r_count;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_HDR_HI;
                        r_err   <= 1'b0;
                        r_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= bus.rx_data;
                        r_state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_count <= w_count;
                        r_idx   <= '0;
                        if (w_count == 16'd0) begin
                            r_state <= S_AFTER_DATA;
                        end else if (w_count > 16'(DEPTH)) begin
                            // Oversize load: nothing is written and no checksum byte is taken.
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_word <= {r_word[23:0], bus.rx_data};
                        r_idx  <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.rx_data;
`endif
                        if (r_idx == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_state <= w_last ? S_AFTER_DATA : S_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_xfer) begin
                        if (bus.rx_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_FINISH;
                    end
                end
`endif
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.imem_we   = (r_state == S_WRITE);
    assign bus.imem_addr = r_addr;
    assign bus.imem_wd   = r_word;
    assign bus.cpu_hold  = (r_state != S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FINISH);
    assign bus.err       = r_err;
endmodule
